// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a DIGITS-wide seven-segment display.
//   A prescaler sets how long each digit slot lasts. The digit index steps
//   once per slot. New data is double-buffered: a load lands in shadow
//   registers and is moved into the display registers only at the frame
//   wrap, so a digit never changes part-way through a frame.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   load          capture value/dp_in/blank_mask/lzs this cycle
//   value         hex nibble per digit, digit 0 = value[3:0] (rightmost)
//   dp_in         decimal point per digit
//   blank_mask    1 = digit dark
//   lzs           leading-zero suppression enable
//   seg           segments a..g on seg[6..0], registered
//   dp            decimal point, registered
//   an            one-hot digit enable, registered
//   pending       shadow holds data waiting for the frame boundary
//   frame_done    one-cycle pulse after the frame wrap
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 50000,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic [DIGITS-1:0]   blank_mask,
    input  logic                lzs,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                pending,
    output logic                frame_done
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  pending_q, pending_d;
    logic                  frame_done_q;
    logic [4*DIGITS-1:0]   sh_value_q, sh_value_d, dsp_value_q, dsp_value_d;
    logic [DIGITS-1:0]     sh_dp_q, sh_dp_d, dsp_dp_q, dsp_dp_d;
    logic [DIGITS-1:0]     sh_blank_q, sh_blank_d, dsp_blank_q, dsp_blank_d;
    logic                  sh_lzs_q, sh_lzs_d, dsp_lzs_q, dsp_lzs_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic tick, wrap;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1111110;
            4'h1:    hex7 = 7'b0110000;
            4'h2:    hex7 = 7'b1101101;
            4'h3:    hex7 = 7'b1111001;
            4'h4:    hex7 = 7'b0110011;
            4'h5:    hex7 = 7'b1011011;
            4'h6:    hex7 = 7'b1011111;
            4'h7:    hex7 = 7'b1110000;
            4'h8:    hex7 = 7'b1111111;
            4'h9:    hex7 = 7'b1111011;
            4'hA:    hex7 = 7'b1110111;
            4'hB:    hex7 = 7'b0011111;
            4'hC:    hex7 = 7'b1001110;
            4'hD:    hex7 = 7'b0111101;
            4'hE:    hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    assign tick = (presc_q == PRESC_LAST);
    assign wrap = tick && (idx_q == IDX_LAST);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (!tick)
            idx_d = idx_q;
        else if (wrap)
            idx_d = '0;
        else
            idx_d = idx_q + IW'(1);
    end

    // Double buffering. A load on the wrap cycle bypasses the shadow and
    // goes straight to the display, so it is never left pending.
    always_comb begin
        pending_d   = pending_q;
        sh_value_d  = sh_value_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        sh_lzs_d    = sh_lzs_q;
        dsp_value_d = dsp_value_q;
        dsp_dp_d    = dsp_dp_q;
        dsp_blank_d = dsp_blank_q;
        dsp_lzs_d   = dsp_lzs_q;
        if (wrap) begin
            pending_d = 1'b0;
            if (load) begin
                dsp_value_d = value;
                dsp_dp_d    = dp_in;
                dsp_blank_d = blank_mask;
                dsp_lzs_d   = lzs;
            end else if (pending_q) begin
                dsp_value_d = sh_value_q;
                dsp_dp_d    = sh_dp_q;
                dsp_blank_d = sh_blank_q;
                dsp_lzs_d   = sh_lzs_q;
            end
        end else if (load) begin
            pending_d  = 1'b1;
            sh_value_d = value;
            sh_dp_d    = dp_in;
            sh_blank_d = blank_mask;
            sh_lzs_d   = lzs;
        end
    end

    // Digit select and decode for the current index. all_zero tracks whether
    // every digit from the top down to i is zero; digit 0 is never suppressed.
    always_comb begin
        logic [3:0] nib;
        logic       cur_dp, cur_blank, cur_sup, all_zero;
        nib       = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        cur_sup   = 1'b0;
        all_zero  = 1'b1;
        an_d      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (dsp_value_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                nib       = dsp_value_q[4*i +: 4];
                cur_dp    = dsp_dp_q[i];
                cur_blank = dsp_blank_q[i];
                cur_sup   = dsp_lzs_q && all_zero && (i != 0);
                an_d[i]   = 1'b1;
            end
        end
        seg_d = (cur_blank || cur_sup) ? 7'b0000000 : hex7(nib);
        dp_d  = cur_blank ? 1'b0 : cur_dp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sh_value_q   <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            sh_lzs_q     <= 1'b0;
            dsp_value_q  <= '0;
            dsp_dp_q     <= '0;
            dsp_blank_q  <= '1;
            dsp_lzs_q    <= 1'b0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            an_q         <= '0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            frame_done_q <= wrap;
            sh_value_q   <= sh_value_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            sh_lzs_q     <= sh_lzs_d;
            dsp_value_q  <= dsp_value_d;
            dsp_dp_q     <= dsp_dp_d;
            dsp_blank_q  <= dsp_blank_d;
            dsp_lzs_q    <= dsp_lzs_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg        = ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp         = ACTIVE_LOW ? ~dp_q  : dp_q;
    assign an         = ACTIVE_LOW ? ~an_q  : an_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: DIGITS=4, PRESCALE=2. dut drives active-high
// pins, dut_n shares all inputs but drives active-low pins.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        rst, load, lzs;
    logic [15:0] value;
    logic [3:0]  dp_in, blank_mask;
    logic [6:0]  seg, seg_n;
    logic        dp, dp_n, pending, pending_n, fd, fd_n;
    logic [3:0]  an, an_n;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(2), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_mask(blank_mask), .lzs(lzs), .seg(seg), .dp(dp), .an(an),
        .pending(pending), .frame_done(fd));

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(2), .ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_mask(blank_mask), .lzs(lzs), .seg(seg_n), .dp(dp_n), .an(an_n),
        .pending(pending_n), .frame_done(fd_n));

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp_in;
        logic [3:0]      blank;
        logic            lzs;
        logic [3:0][6:0] seg_exp;   // [d] = expected segments for digit d
        logic [3:0]      dp_exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge right after the wrap edge.
    task automatic wait_fd();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (fd === 1'b1) seen = 1'b1;
        end
        chk("wait_frame_done", {31'd0, seen}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        logic [3:0] exp_an;
        wait_fd();
        // junk load first; the second load must win
        load = 1'b1; value = ~v.value; dp_in = ~v.dp_in; blank_mask = ~v.blank; lzs = ~v.lzs;
        step();
        value = v.value; dp_in = v.dp_in; blank_mask = v.blank; lzs = v.lzs;
        step();
        load = 1'b0;
        chk($sformatf("v%0d_pending_set", n), {31'd0, pending}, 32'd1);
        repeat (5) step();
        chk($sformatf("v%0d_pending_hold", n), {31'd0, pending}, 32'd1);
        step();
        chk($sformatf("v%0d_frame_done", n), {31'd0, fd}, 32'd1);
        chk($sformatf("v%0d_pending_clr", n), {31'd0, pending}, 32'd0);
        for (int d = 0; d < 4; d++) begin
            step();
            exp_an = 4'b0001 << d;
            chk($sformatf("v%0d_d%0d_an", n, d), {28'd0, an}, {28'd0, exp_an});
            chk($sformatf("v%0d_d%0d_seg", n, d), {25'd0, seg}, {25'd0, v.seg_exp[d]});
            chk($sformatf("v%0d_d%0d_dp", n, d), {31'd0, dp}, {31'd0, v.dp_exp[d]});
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_an;
        logic [3:0] rst_an[9];

        vecs[0] = '{16'h12AF, 4'b0000, 4'b0000, 1'b0,
                    {7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111}, 4'b0000};
        vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1,
                    {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}, 4'b0000};
        vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1,
                    {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0000};
        vecs[3] = '{16'h0000, 4'b1000, 4'b0000, 1'b1,
                    {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b1000};
        vecs[4] = '{16'h3456, 4'b1111, 4'b0101, 1'b0,
                    {7'b1111001, 7'b0000000, 7'b1011011, 7'b0000000}, 4'b1010};
        vecs[5] = '{16'hCDE7, 4'b0000, 4'b0000, 1'b1,
                    {7'b1001110, 7'b0111101, 7'b1001111, 7'b1110000}, 4'b0000};
        vecs[6] = '{16'h0906, 4'b0000, 4'b0000, 1'b1,
                    {7'b0000000, 7'b1111011, 7'b1111110, 7'b1011111}, 4'b0000};
        vecs[7] = '{16'h4000, 4'b0000, 4'b0000, 1'b0,
                    {7'b0110011, 7'b1111110, 7'b1111110, 7'b1111110}, 4'b0000};
        vecs[8] = '{16'h0B00, 4'b0000, 4'b0000, 1'b1,
                    {7'b0000000, 7'b0011111, 7'b1111110, 7'b1111110}, 4'b0000};

        rst_an = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                   4'b1000, 4'b1000, 4'b0001};

        // reset state
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_mask = '0; lzs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_seg", {25'd0, seg}, 32'd0);
        chk("rst_dp", {31'd0, dp}, 32'd0);
        chk("rst_an", {28'd0, an}, 32'd0);
        chk("rst_pending", {31'd0, pending}, 32'd0);
        chk("rst_frame_done", {31'd0, fd}, 32'd0);
        chk("rst_n_seg", {25'd0, seg_n}, 32'h7F);
        chk("rst_n_an", {28'd0, an_n}, 32'hF);
        chk("rst_n_dp", {31'd0, dp_n}, 32'd1);

        // dark scan after release
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("scan%0d_an", k), {28'd0, an}, {28'd0, rst_an[k-1]});
            chk($sformatf("scan%0d_seg", k), {25'd0, seg}, 32'd0);
            chk($sformatf("scan%0d_fd", k), {31'd0, fd}, (k == 8) ? 32'd1 : 32'd0);
        end

        for (int n = 0; n < 9; n++)
            run_vec(vecs[n], n);

        // load on the wrap-tick cycle goes straight to the display
        wait_fd();
        repeat (7) step();
        chk("col_pending_before", {31'd0, pending}, 32'd0);
        load = 1'b1; value = 16'h8888; dp_in = 4'b0001; blank_mask = 4'b0000; lzs = 1'b0;
        step();
        load = 1'b0;
        chk("col_frame_done", {31'd0, fd}, 32'd1);
        chk("col_pending", {31'd0, pending}, 32'd0);
        for (int d = 0; d < 4; d++) begin
            step();
            exp_an = 4'b0001 << d;
            chk($sformatf("col_d%0d_an", d), {28'd0, an}, {28'd0, exp_an});
            chk($sformatf("col_d%0d_seg", d), {25'd0, seg}, 32'h7F);
            chk($sformatf("col_d%0d_dp", d), {31'd0, dp}, (d == 0) ? 32'd1 : 32'd0);
            if (d == 0) begin
                chk("pol_an", {28'd0, an_n}, 32'hE);
                chk("pol_seg", {25'd0, seg_n}, 32'd0);
                chk("pol_dp", {31'd0, dp_n}, 32'd0);
            end
            step();
        end

        // reset while data is pending at index 2
        wait_fd();
        load = 1'b1; value = 16'h1234; dp_in = 4'b0000; blank_mask = 4'b0000; lzs = 1'b0;
        step();
        load = 1'b0;
        repeat (4) step();
        chk("mid_an_idx2", {28'd0, an}, 32'h4);
        chk("mid_pending", {31'd0, pending}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_seg", {25'd0, seg}, 32'd0);
        chk("mid_rst_an", {28'd0, an}, 32'd0);
        chk("mid_rst_dp", {31'd0, dp}, 32'd0);
        chk("mid_rst_pending", {31'd0, pending}, 32'd0);
        chk("mid_rst_n_an", {28'd0, an_n}, 32'hF);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("mid_restart_an", {28'd0, an}, 32'h1);
        chk("mid_restart_seg", {25'd0, seg}, 32'd0);
        repeat (7) step();
        chk("mid_restart_fd", {31'd0, fd}, 32'd1);
        chk("mid_restart_pending", {31'd0, pending}, 32'd0);
        step();
        chk("mid_discard_an", {28'd0, an}, 32'h1);
        chk("mid_discard_seg", {25'd0, seg}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 SHALL have parameter PRESCALE, default 50000: clocks per digit slot, minimum 1.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 inverts seg, dp and an at the pins.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk (in, 1, rising-edge clock) and rst (in, 1, async active-high reset).
REQ-005 SHALL have port load, in, 1: capture value, dp_in, blank_mask and lzs this cycle.
REQ-006 SHALL have port value, in, 4*DIGITS: hex nibble per digit, digit i = value[4i+3:4i], digit 0 rightmost.
REQ-007 SHALL have port dp_in, in, DIGITS: decimal point per digit.
REQ-008 SHALL have port blank_mask, in, DIGITS: 1 = digit dark.
REQ-009 SHALL have port lzs, in, 1: leading-zero suppression enable.
REQ-010 SHALL have port seg, out, 7: seg[6..0] = a,b,c,d,e,f,g, registered.
REQ-011 SHALL have port dp, out, 1: decimal point, registered.
REQ-012 SHALL have port an, out, DIGITS: one-hot digit enable, registered.
REQ-013 SHALL have port pending, out, 1: captured data waiting for frame boundary.
REQ-014 SHALL have port frame_done, out, 1: one-cycle pulse at frame wrap.

Function
REQ-015 SHALL run prescaler 0..PRESCALE-1, wrap to 0, and assert internal tick when it equals PRESCALE-1; PRESCALE=1 gives a tick every cycle.
REQ-016 SHALL advance digit index 0..DIGITS-1 on tick and wrap DIGITS-1 -> 0; that wrap is the frame boundary.
REQ-017 SHALL pulse frame_done high for exactly the cycle after the wrap tick.
REQ-018 SHALL, on load when not at the frame boundary, store inputs into shadow registers and set pending=1; a later load overwrites the shadow (last wins).
REQ-019 SHALL, at the frame boundary, copy shadow to display registers if pending=1 and clear pending.
REQ-020 SHALL, when load coincides with the boundary tick, copy the load inputs directly to display registers and leave pending=0.
REQ-021 SHALL not change display registers mid-frame, so no digit tears.
REQ-022 SHALL decode nibbles as hex, active-high internal: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-023 SHALL register seg, dp and an one clock after the index changes, with an one-hot at the current index (1-cycle latency).
REQ-024 SHALL, for a blanked digit, drive seg=0000000 and dp=0 internal while an stays active for its slot.
REQ-025 SHALL, with lzs=1, blank zero nibbles from digit DIGITS-1 downward until the first nonzero digit; digit 0 is never suppressed, and dp_in still shows on suppressed digits.
REQ-026 SHALL invert seg, dp and an after the output registers when ACTIVE_LOW=1.

Reset
REQ-027 SHALL, on rst asserted asynchronously, clear prescaler, index, pending, frame_done, shadow and display values, and set display blank_mask to all ones.
REQ-028 SHALL drive all outputs inactive immediately during reset: internal seg=0, dp=0, an=0, then polarity per ACTIVE_LOW.
REQ-029 SHALL start scanning at digit 0 with a fresh prescaler count after rst deasserts; a load arriving mid-frame is discarded.

Verification (DIGITS=4, PRESCALE=2, ACTIVE_LOW=0 unless stated)
REQ-030 SHALL be checked for reset: rst=1 -> seg=0000000, dp=0, an=0000, pending=0, frame_done=0; after release the display stays dark with an cycling 0001,0010,0100,1000.
REQ-031 SHALL be checked for display: load value=16'h12AF, dp_in=0, blank_mask=0 mid-frame -> pending=1 until the boundary; next frame shows an=0001 seg=1000111, an=0010 seg=1110111, an=0100 seg=1101101, an=1000 seg=0110000.
REQ-032 SHALL be checked for suppression: lzs=1, value=16'h0050 -> digits 3,2 give seg=0000000; digit 1 seg=1011011; digit 0 seg=1111110; with value=16'h0000 only digit 0 shows 1111110.
REQ-033 SHALL be checked for boundary collision: load of 16'h8888 on the wrap-tick cycle -> pending stays 0 and the frame starting next shows 1111111 on all digits.
REQ-034 SHALL be checked for polarity: ACTIVE_LOW=1, digit 0 = 8, dp_in[0]=1 -> an=1110, seg=0000000, dp=0.
REQ-035 SHALL be checked for reset mid-operation: rst pulsed while pending=1 at index 2 -> pending=0, outputs inactive at once, scan restarts at digit 0.
